// File: rtl/butterfly_radix2_pipe.sv
// Three-stage pipelined radix-2 DIF butterfly: y0 = x0 + x1, y1 = (x0 - x1) * W,
// with rounding, optional /2 scaling and saturation. Define BFLY_OVF_CNT_EN to add ovf_count.
module butterfly_radix2_pipe #(
  parameter int WIDTH    = 16,
  parameter int TW_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       inverse,
  input  logic                       scale,
  input  logic signed [WIDTH-1:0]    x0_real,
  input  logic signed [WIDTH-1:0]    x0_imag,
  input  logic signed [WIDTH-1:0]    x1_real,
  input  logic signed [WIDTH-1:0]    x1_imag,
  input  logic signed [TW_WIDTH-1:0] tw_real,
  input  logic signed [TW_WIDTH-1:0] tw_imag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [WIDTH-1:0]    y0_real,
  output logic signed [WIDTH-1:0]    y0_imag,
  output logic signed [WIDTH-1:0]    y1_real,
  output logic signed [WIDTH-1:0]    y1_imag,
  output logic                       ovf,
  output logic                       ovf_sticky
`ifdef BFLY_OVF_CNT_EN
  ,
  output logic [15:0]                ovf_count
`endif
);

  localparam int SW = WIDTH + 1;
  localparam int PW = WIDTH + TW_WIDTH + 2;
  localparam int RW = PW + 1;

  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(RW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [RW-1:0] ONE     = {{(RW-1){1'b0}}, 1'b1};
  localparam logic signed [RW-1:0] RND_LO  = ONE <<< (TW_WIDTH-2);
  localparam logic signed [RW-1:0] RND_HI  = ONE <<< (TW_WIDTH-1);

  // Returns {clamped, value}
  function automatic logic [WIDTH:0] sat_f(input logic signed [RW-1:0] v);
    if (v > SAT_MAX)      return {1'b1, SAT_MAX[WIDTH-1:0]};
    else if (v < SAT_MIN) return {1'b1, SAT_MIN[WIDTH-1:0]};
    else                  return {1'b0, v[WIDTH-1:0]};
  endfunction

  logic adv;

  // Stage 1 registers
  logic                       v1_q;
  logic signed [SW-1:0]       sr1_q, si1_q, dr1_q, di1_q;
  logic signed [SW-1:0]       sr1_d, si1_d, dr1_d, di1_d;
  logic signed [TW_WIDTH-1:0] tr1_q;
  logic signed [TW_WIDTH:0]   ti1_q, ti1_d;
  logic                       sc1_q;

  // Stage 2 registers
  logic                       v2_q;
  logic signed [SW-1:0]       sr2_q, si2_q;
  logic signed [PW-1:0]       pr2_q, pi2_q, pr2_d, pi2_d;
  logic                       sc2_q;

  // Stage 3 (output) registers
  logic                       v3_q;
  logic signed [WIDTH-1:0]    y0r_q, y0i_q, y1r_q, y1i_q;
  logic signed [WIDTH-1:0]    y0r_d, y0i_d, y1r_d, y1i_d;
  logic                       ovf_q, ovf_d;
  logic                       sticky_q, sticky_d;

  assign adv      = out_ready | ~v3_q;
  assign in_ready = adv;

  // S1: sum/diff at WIDTH+1 bits; conjugation folded into the twiddle imag part
  always_comb begin
    logic signed [TW_WIDTH:0] tie;
    sr1_d = {x0_real[WIDTH-1], x0_real} + {x1_real[WIDTH-1], x1_real};
    si1_d = {x0_imag[WIDTH-1], x0_imag} + {x1_imag[WIDTH-1], x1_imag};
    dr1_d = {x0_real[WIDTH-1], x0_real} - {x1_real[WIDTH-1], x1_real};
    di1_d = {x0_imag[WIDTH-1], x0_imag} - {x1_imag[WIDTH-1], x1_imag};
    tie   = {tw_imag[TW_WIDTH-1], tw_imag};
    ti1_d = inverse ? -tie : tie;
  end

  // S2: complex multiply, full precision
  always_comb begin
    logic signed [PW-1:0] ar, ai, br, bi;
    ar    = {{(PW-SW){dr1_q[SW-1]}}, dr1_q};
    ai    = {{(PW-SW){di1_q[SW-1]}}, di1_q};
    br    = {{(PW-TW_WIDTH){tr1_q[TW_WIDTH-1]}}, tr1_q};
    bi    = {{(PW-TW_WIDTH-1){ti1_q[TW_WIDTH]}}, ti1_q};
    pr2_d = ar * br - ai * bi;
    pi2_d = ar * bi + ai * br;
  end

  // S3: round half up, shift, saturate
  always_comb begin
    logic signed [RW-1:0] e1r, e1i, e0r, e0i;
    logic signed [RW-1:0] r1r, r1i, r0r, r0i;
    logic [WIDTH:0]       s1r, s1i, s0r, s0i;
    e1r = {{(RW-PW){pr2_q[PW-1]}}, pr2_q};
    e1i = {{(RW-PW){pi2_q[PW-1]}}, pi2_q};
    e0r = {{(RW-SW){sr2_q[SW-1]}}, sr2_q};
    e0i = {{(RW-SW){si2_q[SW-1]}}, si2_q};
    r1r = sc2_q ? ((e1r + RND_HI) >>> TW_WIDTH) : ((e1r + RND_LO) >>> (TW_WIDTH-1));
    r1i = sc2_q ? ((e1i + RND_HI) >>> TW_WIDTH) : ((e1i + RND_LO) >>> (TW_WIDTH-1));
    r0r = sc2_q ? ((e0r + ONE) >>> 1) : e0r;
    r0i = sc2_q ? ((e0i + ONE) >>> 1) : e0i;
    s1r = sat_f(r1r);
    s1i = sat_f(r1i);
    s0r = sat_f(r0r);
    s0i = sat_f(r0i);
    y0r_d = s0r[WIDTH-1:0];
    y0i_d = s0i[WIDTH-1:0];
    y1r_d = s1r[WIDTH-1:0];
    y1i_d = s1i[WIDTH-1:0];
    ovf_d = s0r[WIDTH] | s0i[WIDTH] | s1r[WIDTH] | s1i[WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      sr1_q <= '0;
      si1_q <= '0;
      dr1_q <= '0;
      di1_q <= '0;
      tr1_q <= '0;
      ti1_q <= '0;
      sc1_q <= 1'b0;
      v2_q  <= 1'b0;
      sr2_q <= '0;
      si2_q <= '0;
      pr2_q <= '0;
      pi2_q <= '0;
      sc2_q <= 1'b0;
      v3_q  <= 1'b0;
      y0r_q <= '0;
      y0i_q <= '0;
      y1r_q <= '0;
      y1i_q <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      v1_q <= in_valid;
      if (in_valid) begin
        sr1_q <= sr1_d;
        si1_q <= si1_d;
        dr1_q <= dr1_d;
        di1_q <= di1_d;
        tr1_q <= tw_real;
        ti1_q <= ti1_d;
        sc1_q <= scale;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        sr2_q <= sr1_q;
        si2_q <= si1_q;
        pr2_q <= pr2_d;
        pi2_q <= pi2_d;
        sc2_q <= sc1_q;
      end
      v3_q <= v2_q;
      if (v2_q) begin
        y0r_q <= y0r_d;
        y0i_q <= y0i_d;
        y1r_q <= y1r_d;
        y1i_q <= y1i_d;
      end
      ovf_q <= v2_q & ovf_d;
    end
  end

  always_comb begin
    sticky_d = sticky_q;
    if (clear)                         sticky_d = 1'b0;
    else if (v3_q & out_ready & ovf_q) sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 1'b0;
    else        sticky_q <= sticky_d;
  end

`ifdef BFLY_OVF_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                                      cnt_d = '0;
    else if (v3_q & out_ready & ovf_q & ~(&cnt_q))  cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign ovf_count = cnt_q;
`endif

  assign out_valid  = v3_q;
  assign y0_real    = y0r_q;
  assign y0_imag    = y0i_q;
  assign y1_real    = y1r_q;
  assign y1_imag    = y1i_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_butterfly_radix2_pipe.sv
// Self-checking bench for butterfly_radix2_pipe: directed cases plus randomized
// stream against an arithmetic reference model and scoreboard.
module tb_butterfly_radix2_pipe;

  logic clk, rst_n, clear, in_valid, in_ready, inverse, scale;
  logic signed [15:0] x0r, x0i, x1r, x1i, twr, twi;
  logic out_valid, out_ready, ovf, ovf_sticky;
  logic signed [15:0] y0r, y0i, y1r, y1i;
`ifdef BFLY_OVF_CNT_EN
  logic [15:0] ovf_count;
`endif

  butterfly_radix2_pipe #(.WIDTH(16), .TW_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .inverse(inverse), .scale(scale),
    .x0_real(x0r), .x0_imag(x0i), .x1_real(x1r), .x1_imag(x1i),
    .tw_real(twr), .tw_imag(twi),
    .out_valid(out_valid), .out_ready(out_ready),
    .y0_real(y0r), .y0_imag(y0i), .y1_real(y1r), .y1_imag(y1i),
    .ovf(ovf), .ovf_sticky(ovf_sticky)
`ifdef BFLY_OVF_CNT_EN
    , .ovf_count(ovf_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  typedef struct {
    longint y0r, y0i, y1r, y1i;
    bit     ovf;
  } exp_t;

  function automatic longint clampv(input longint v, inout bit o);
    if (v > 32767)  begin o = 1'b1; return 32767;  end
    if (v < -32768) begin o = 1'b1; return -32768; end
    return v;
  endfunction

  function automatic longint rnd_shift(input longint v, input int sh);
    if (sh == 0) return v;
    return (v + (longint'(1) <<< (sh - 1))) >>> sh;
  endfunction

  function automatic exp_t model(input longint a0r, a0i, a1r, a1i, wr, wi, input bit inv, input bit sc);
    exp_t   e;
    bit     o = 1'b0;
    longint dr = a0r - a1r, di = a0i - a1i;
    longint ti = inv ? -wi : wi;
    e.y0r = clampv(rnd_shift(a0r + a1r, int'(sc)), o);
    e.y0i = clampv(rnd_shift(a0i + a1i, int'(sc)), o);
    e.y1r = clampv(rnd_shift(dr * wr - di * ti, 15 + int'(sc)), o);
    e.y1i = clampv(rnd_shift(dr * ti + di * wr, 15 + int'(sc)), o);
    e.ovf = o;
    return e;
  endfunction

  exp_t exp_q[$];
  bit   sticky_m = 1'b0;
  int   cnt_m    = 0;
  int   rx_cnt   = 0;
  bit   acc_in   = 1'b0;
  bit   saw_stall = 1'b0;

  // Scoreboard: observe handshakes half a cycle before the edge that completes them
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      bit   acc_out;
      check_eq("sticky", ovf_sticky, sticky_m);
`ifdef BFLY_OVF_CNT_EN
      check_eq("count", ovf_count, cnt_m);
`endif
      acc_out = out_valid && out_ready;
      e.ovf = 1'b0;
      if (acc_out) begin
        if (exp_q.size() == 0) check_eq("unexpected_out", 1, 0);
        else begin
          e = exp_q.pop_front();
          check_eq("y0r", y0r, e.y0r);
          check_eq("y0i", y0i, e.y0i);
          check_eq("y1r", y1r, e.y1r);
          check_eq("y1i", y1i, e.y1i);
          check_eq("ovf", ovf, e.ovf);
          rx_cnt++;
        end
      end
      acc_in = in_valid && in_ready;
      if (acc_in) exp_q.push_back(model(x0r, x0i, x1r, x1i, twr, twi, inverse, scale));
      if (in_valid && !in_ready) saw_stall = 1'b1;
      if (clear) begin
        sticky_m = 1'b0;
        cnt_m    = 0;
      end else if (acc_out && e.ovf) begin
        sticky_m = 1'b1;
        if (cnt_m < 65535) cnt_m++;
      end
    end
  end

  task automatic set_in(input logic signed [15:0] a0r, a0i, a1r, a1i, wr, wi, input bit inv, sc);
    x0r = a0r; x0i = a0i; x1r = a1r; x1i = a1i; twr = wr; twi = wi;
    inverse = inv; scale = sc;
  endtask

  // Presents one beat for one cycle; returns at posedge+1 after the accepting edge
  task automatic send1(input logic signed [15:0] a0r, a0i, a1r, a1i, wr, wi, input bit inv, sc);
    set_in(a0r, a0i, a1r, a1i, wr, wi, inv, sc);
    in_valid = 1'b1;
    check_eq("send_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    @(posedge clk); #1;
    check_eq("lat2_not_valid", out_valid, 0);
    @(posedge clk); #1;
    check_eq("lat3_valid", out_valid, 1);
  endtask

  function automatic logic signed [15:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return 16'sh8000;
      1:       return 16'sh7fff;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sent, rx0;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_sticky", ovf_sticky, 0);
    #9 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Case 1: basic butterfly and latency
    send1(1000, 0, 200, 0, 32767, 0, 0, 0);
    wait_out();
    check_eq("t1_y0r", y0r, 1200);
    check_eq("t1_y0i", y0i, 0);
    check_eq("t1_y1r", y1r, 800);
    check_eq("t1_y1i", y1i, 0);
    check_eq("t1_ovf", ovf, 0);

    // Case 2: forward vs inverse twiddle
    send1(100, 0, 0, 0, 0, -32767, 0, 0);
    wait_out();
    check_eq("t2_fwd_y1r", y1r, 0);
    check_eq("t2_fwd_y1i", y1i, -100);
    send1(100, 0, 0, 0, 0, -32767, 1, 0);
    wait_out();
    check_eq("t2_inv_y1i", y1i, 100);

    // Case 3: saturation, scaling, sticky and clear
    send1(32767, 0, 32767, 0, 32767, 0, 0, 0);
    wait_out();
    check_eq("t3_y0r", y0r, 32767);
    check_eq("t3_ovf", ovf, 1);
    @(posedge clk); #1;
    check_eq("t3_sticky", ovf_sticky, 1);
    send1(32767, 0, 32767, 0, 32767, 0, 0, 1);
    wait_out();
    check_eq("t3s_y0r", y0r, 32767);
    check_eq("t3s_ovf", ovf, 0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check_eq("t3_cleared", ovf_sticky, 0);

    // Boundary: W = -1.0 with the most negative difference saturates
    send1(-32768, 0, 32767, 0, -32768, 0, 0, 0);
    wait_out();
    check_eq("tb_y1r", y1r, 32767);
    check_eq("tb_ovf", ovf, 1);
    @(posedge clk); #1;

    // Case 4: 8-beat stream with 5-cycle backpressure
    rx0 = rx_cnt; sent = 0; saw_stall = 1'b0;
    for (int c = 0; c < 60 && (rx_cnt - rx0) < 8; c++) begin
      if (in_valid && acc_in) sent++;
      out_ready = !(c >= 3 && c < 8);
      in_valid  = (sent < 8);
      set_in(16'(sent * 100 + 7), 16'(-sent * 50), 16'(sent * 30), 16'(sent), 16'(20000 - sent * 999), 16'(sent * 1234), sent[0], sent[1]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check_eq("t4_received", rx_cnt - rx0, 8);
    check_eq("t4_stalled", saw_stall, 1);

    // Case 5: asynchronous reset mid-stream
    send1(32767, 0, 32767, 0, 32767, 0, 0, 0);
    wait_out();
    @(posedge clk); #1;
    check_eq("t5_sticky_pre", ovf_sticky, 1);
    out_ready = 1'b0;
    send1(1, 2, 3, 4, 32767, 0, 0, 0);
    wait_out();
    #1 rst_n = 1'b0;
    #1;
    check_eq("t5_out_valid", out_valid, 0);
    check_eq("t5_y0r", y0r, 0);
    check_eq("t5_y0i", y0i, 0);
    check_eq("t5_sticky", ovf_sticky, 0);
    exp_q.delete();
    sticky_m = 1'b0; cnt_m = 0;
    out_ready = 1'b1;
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("t5_in_ready", in_ready, 1);
    send1(1000, 0, 200, 0, 32767, 0, 0, 0);
    wait_out();
    check_eq("t5_new_y0r", y0r, 1200);
    @(posedge clk); #1;

`ifdef BFLY_OVF_CNT_EN
    // Case 6: saturation event counter
    for (int i = 0; i < 3; i++) send1(32767, 0, 32767, 0, 32767, 0, 0, 0);
    repeat (3) begin @(posedge clk); #1; end
    check_eq("t6_count3", ovf_count, 3);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check_eq("t6_count0", ovf_count, 0);
`endif

    // Randomized stream with random backpressure and occasional clear
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 63) == 0);
      if (!in_valid || acc_in) begin
        in_valid = ($urandom_range(0, 3) != 0);
        set_in(rnd_val(), rnd_val(), rnd_val(), rnd_val(), rnd_val(), rnd_val(),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
      @(posedge clk); #1;
    end
    check_eq("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
